// File: rtl/peak_lsu.sv
// Single-outstanding load/store unit between the execute-stage ALU and a valid/ready data bus.
// Optional misaligned-access trap: define PEAK_LSU_MISALIGN_TRAP_EN.
module peak_lsu #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ISSUE_VALID,
    output logic        ISSUE_READY,
    input  logic        INST_LB,
    input  logic        INST_LH,
    input  logic        INST_LW,
    input  logic        INST_LBU,
    input  logic        INST_LHU,
    input  logic        INST_SB,
    input  logic        INST_SH,
    input  logic        INST_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA_IN,
    output logic        D_MEM_VALID,
    input  logic        D_MEM_READY,
    output logic [31:0] D_MEM_ADDR,
    output logic [3:0]  D_MEM_WSTRB,
    output logic [31:0] D_MEM_WDATA,
    input  logic [31:0] D_MEM_RDATA,
    output logic        DONE,
    output logic        LOAD_VALID,
    output logic [31:0] LOAD_DATA,
    output logic        BUS_ERR,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_t      state_r;
    op_t         op_r;
    logic [1:0]  lane_r;
    logic [31:0] to_cnt_r;
    op_t         sel_op_s;
    logic        sel_valid_s;
    logic        misalign_s;

    function automatic logic is_load(input op_t op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input op_t op, input logic [1:0] lane);
        case (op)
            OP_SB:   return 4'b0001 << lane;
            OP_SH:   return 4'b0011 << {lane[1], 1'b0};
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input op_t op, input logic [31:0] wd);
        case (op)
            OP_SB:   return {4{wd[7:0]}};
            OP_SH:   return {2{wd[15:0]}};
            OP_SW:   return wd;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Lane select ignores ADDR[0] for halfwords, so an unchecked offset-3 halfword reads lanes 3..2.
    function automatic logic [31:0] load_extract(input op_t op, input logic [1:0] lane,
                                                 input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        byte_v = rdata[{lane, 3'b000} +: 8];
        half_v = rdata[{lane[1], 4'b0000} +: 16];
        case (op)
            OP_LB:   return {{24{byte_v[7]}}, byte_v};
            OP_LBU:  return {24'h00_0000, byte_v};
            OP_LH:   return {{16{half_v[15]}}, half_v};
            OP_LHU:  return {16'h0000, half_v};
            OP_LW:   return rdata;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Priority decode of the (nominally one-hot) instruction strobes.
    always_comb begin
        sel_op_s    = OP_LW;
        sel_valid_s = 1'b1;
        if (INST_LW) begin
            sel_op_s = OP_LW;
        end else if (INST_LH) begin
            sel_op_s = OP_LH;
        end else if (INST_LHU) begin
            sel_op_s = OP_LHU;
        end else if (INST_LB) begin
            sel_op_s = OP_LB;
        end else if (INST_LBU) begin
            sel_op_s = OP_LBU;
        end else if (INST_SW) begin
            sel_op_s = OP_SW;
        end else if (INST_SH) begin
            sel_op_s = OP_SH;
        end else if (INST_SB) begin
            sel_op_s = OP_SB;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

`ifdef PEAK_LSU_MISALIGN_TRAP_EN
    // Alignment check on the access being offered.
    always_comb begin
        case (sel_op_s)
            OP_LH, OP_LHU, OP_SH: misalign_s = ADDR[0];
            OP_LW, OP_SW:         misalign_s = (ADDR[1:0] != 2'b00);
            default:              misalign_s = 1'b0;
        endcase
    end
`else
    assign misalign_s = 1'b0;
`endif

    // Control FSM; every output is a register updated here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_LB;
            lane_r      <= 2'b00;
            to_cnt_r    <= 32'd0;
            ISSUE_READY <= 1'b1;
            D_MEM_VALID <= 1'b0;
            D_MEM_ADDR  <= 32'h0000_0000;
            D_MEM_WSTRB <= 4'b0000;
            D_MEM_WDATA <= 32'h0000_0000;
            DONE        <= 1'b0;
            LOAD_VALID  <= 1'b0;
            LOAD_DATA   <= 32'h0000_0000;
            BUS_ERR     <= 1'b0;
            MISALIGN    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    DONE <= 1'b0;
                    if (ISSUE_VALID && sel_valid_s) begin
                        op_r        <= sel_op_s;
                        lane_r      <= ADDR[1:0];
                        to_cnt_r    <= 32'd0;
                        ISSUE_READY <= 1'b0;
                        if (misalign_s) begin
                            state_r    <= ST_RESP;
                            DONE       <= 1'b1;
                            MISALIGN   <= 1'b1;
                            LOAD_VALID <= 1'b0;
                            BUS_ERR    <= 1'b0;
                        end else begin
                            state_r     <= ST_REQ;
                            D_MEM_VALID <= 1'b1;
                            D_MEM_ADDR  <= {ADDR[31:2], 2'b00};
                            D_MEM_WSTRB <= store_strb(sel_op_s, ADDR[1:0]);
                            D_MEM_WDATA <= store_wdata(sel_op_s, WDATA_IN);
                        end
                    end else begin
                        ISSUE_READY <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // READY in the expiry cycle still completes normally.
                    if (D_MEM_READY) begin
                        state_r     <= ST_RESP;
                        D_MEM_VALID <= 1'b0;
                        DONE        <= 1'b1;
                        if (is_load(op_r)) begin
                            LOAD_VALID <= 1'b1;
                            LOAD_DATA  <= load_extract(op_r, lane_r, D_MEM_RDATA);
                        end else begin
                            LOAD_VALID <= 1'b0;
                        end
                    end else if (TO_EN && (to_cnt_r == TO_LAST)) begin
                        state_r     <= ST_RESP;
                        D_MEM_VALID <= 1'b0;
                        DONE        <= 1'b1;
                        BUS_ERR     <= 1'b1;
                        LOAD_VALID  <= 1'b0;
                    end else begin
                        to_cnt_r <= to_cnt_r + 32'd1;
                    end
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    ISSUE_READY <= 1'b1;
                    to_cnt_r    <= 32'd0;
                    DONE        <= 1'b0;
                    LOAD_VALID  <= 1'b0;
                    BUS_ERR     <= 1'b0;
                    MISALIGN    <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    ISSUE_READY <= 1'b1;
                    D_MEM_VALID <= 1'b0;
                    DONE        <= 1'b0;
                    LOAD_VALID  <= 1'b0;
                    BUS_ERR     <= 1'b0;
                    MISALIGN    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peak_lsu.sv
// Scoreboard bench for peak_lsu: expected completions and bus requests are queued at issue
// and compared when the DUT presents them. Built with TIMEOUT_CYCLES=3.
module tb_peak_lsu;

    localparam int TMO = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [7:0]  inst;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic        d_mem_valid;
    logic        d_mem_ready;
    logic [31:0] d_mem_addr;
    logic [3:0]  d_mem_wstrb;
    logic [31:0] d_mem_wdata;
    logic [31:0] d_mem_rdata;
    logic        done;
    logic        load_valid;
    logic [31:0] load_data;
    logic        bus_err;
    logic        misalign;

    always #5 clk = ~clk;

    peak_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(clk), .RST(rst), .ISSUE_VALID(issue_valid), .ISSUE_READY(issue_ready),
        .INST_LB(inst[0]), .INST_LH(inst[1]), .INST_LW(inst[2]), .INST_LBU(inst[3]),
        .INST_LHU(inst[4]), .INST_SB(inst[5]), .INST_SH(inst[6]), .INST_SW(inst[7]),
        .ADDR(addr), .WDATA_IN(wdata_in),
        .D_MEM_VALID(d_mem_valid), .D_MEM_READY(d_mem_ready), .D_MEM_ADDR(d_mem_addr),
        .D_MEM_WSTRB(d_mem_wstrb), .D_MEM_WDATA(d_mem_wdata), .D_MEM_RDATA(d_mem_rdata),
        .DONE(done), .LOAD_VALID(load_valid), .LOAD_DATA(load_data),
        .BUS_ERR(bus_err), .MISALIGN(misalign)
    );

    typedef struct {
        logic        load_valid;
        logic [31:0] load_data;
        logic        bus_err;
        logic        misalign;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_load = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // inst bit index: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
    function automatic int pick_op(input logic [7:0] m);
        if (m[2]) return 2;
        if (m[1]) return 1;
        if (m[4]) return 4;
        if (m[0]) return 0;
        if (m[3]) return 3;
        if (m[7]) return 7;
        if (m[6]) return 6;
        return 5;
    endfunction

    function automatic logic [31:0] model_load(input int op, input logic [1:0] lane,
                                               input logic [31:0] rdv);
        logic [31:0] b, h;
        b = (rdv >> (8 * int'(lane))) & 32'h0000_00FF;
        h = (rdv >> (lane[1] ? 16 : 0)) & 32'h0000_FFFF;
        case (op)
            0:       return b[7] ? (b | 32'hFFFF_FF00) : b;
            3:       return b;
            1:       return h[15] ? (h | 32'hFFFF_0000) : h;
            4:       return h;
            2:       return rdv;
            default: return 32'h0;
        endcase
    endfunction

    // Issue one op, serve the bus with `waits` unready cycles, check completion.
    task automatic run_op(input logic [7:0] m, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] rdv, input int waits, input bit inject);
        int   op;
        int   k;
        int   nw;
        logic misal;
        logic tmo;
        bit   seen;
        bit   done_seen;
        exp_t e;
        bus_t b;
        bus_t first_b;
        op    = pick_op(m);
        misal = 1'b0;
`ifdef PEAK_LSU_MISALIGN_TRAP_EN
        if ((op == 1 || op == 4 || op == 6) && a[0]) misal = 1'b1;
        if ((op == 2 || op == 7) && a[1:0] != 2'b00) misal = 1'b1;
`endif
        tmo          = !misal && (waits >= TMO);
        e.misalign   = misal;
        e.bus_err    = tmo;
        e.load_valid = (op <= 4) && !misal && !tmo;
        e.load_data  = e.load_valid ? model_load(op, a[1:0], rdv) : last_load;
        e.lat        = misal ? 1 : (tmo ? 1 + TMO : 2 + waits);
        exp_q.push_back(e);
        if (!misal) begin
            b.addr = a & 32'hFFFF_FFFC;
            case (op)
                5:       begin b.strb = 4'(1 << a[1:0]); b.wdata = {24'h0, w[7:0]} * 32'h0101_0101; end
                6:       begin b.strb = a[1] ? 4'b1100 : 4'b0011; b.wdata = {16'h0, w[15:0]} * 32'h0001_0001; end
                7:       begin b.strb = 4'b1111; b.wdata = w; end
                default: begin b.strb = 4'b0000; b.wdata = 32'h0; end
            endcase
            bus_q.push_back(b);
        end
        check_eq("idle_ready", issue_ready, 1'b1);
        issue_valid = 1'b1; inst = m; addr = a; wdata_in = w;
        step();
        issue_valid = 1'b0; inst = 8'h00;
        k = 1; nw = 0; seen = 0; done_seen = 0;
        first_b = '{32'h0, 4'h0, 32'h0};
        while (k <= 40 && !done_seen) begin
            d_mem_ready = 1'b0;
            d_mem_rdata = 32'hDEAD_BEEF;
            if (done) begin
                e = exp_q.pop_front();
                check_eq("latency", k, e.lat);
                check_eq("load_valid", load_valid, e.load_valid);
                check_eq("bus_err", bus_err, e.bus_err);
                check_eq("misalign", misalign, e.misalign);
                check_eq("load_data", load_data, e.load_data);
                if (e.load_valid) last_load = e.load_data;
                done_seen = 1;
            end else begin
                if (d_mem_valid) begin
                    if (!seen) begin
                        if (bus_q.size() == 0) begin
                            check_eq("unexpected_req", d_mem_valid, 1'b0);
                            first_b = '{d_mem_addr, d_mem_wstrb, d_mem_wdata};
                        end else begin
                            first_b = bus_q.pop_front();
                            check_eq("req_addr", d_mem_addr, first_b.addr);
                            check_eq("req_wstrb", d_mem_wstrb, first_b.strb);
                            check_eq("req_wdata", d_mem_wdata, first_b.wdata);
                        end
                        seen = 1;
                    end else begin
                        check_eq("hold_addr", d_mem_addr, first_b.addr);
                        check_eq("hold_wstrb", d_mem_wstrb, first_b.strb);
                        check_eq("hold_wdata", d_mem_wdata, first_b.wdata);
                    end
                    check_eq("busy_ready", issue_ready, 1'b0);
                    if (nw == waits) begin
                        d_mem_ready = 1'b1;
                        d_mem_rdata = rdv;
                    end else begin
                        nw++;
                        if (inject && nw == 1) begin
                            issue_valid = 1'b1; inst = 8'h80;
                        end
                    end
                end
                step();
                issue_valid = 1'b0; inst = 8'h00;
                k++;
            end
        end
        if (!done_seen) begin
            check_eq("done_timeout", done, 1'b1);
            exp_q.delete();
            bus_q.delete();
        end
        if (!misal && !seen) check_eq("missing_req", d_mem_valid, 1'b1);
        d_mem_ready = 1'b0;
        d_mem_rdata = 32'hDEAD_BEEF;
        step();
        check_eq("done_pulse", done, 1'b0);
        check_eq("ready_back", issue_ready, 1'b1);
        check_eq("no_req", d_mem_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; issue_valid = 1'b0; inst = 8'h00; addr = 32'h0; wdata_in = 32'h0;
        d_mem_ready = 1'b0; d_mem_rdata = 32'hDEAD_BEEF;
        step();
        step();
        check_eq("rst_issue_ready", issue_ready, 1'b1);
        check_eq("rst_valid", d_mem_valid, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_load_valid", load_valid, 1'b0);
        check_eq("rst_load_data", load_data, 32'h0);
        check_eq("rst_bus_err", bus_err, 1'b0);
        check_eq("rst_misalign", misalign, 1'b0);
        check_eq("rst_wstrb", d_mem_wstrb, 4'h0);
        rst = 1'b0;
        step();

        run_op(8'h04, 32'h0000_1000, 32'h0, 32'h8765_4321, 0, 0);
        check_eq("tp_lw", load_data, 32'h8765_4321);
        run_op(8'h01, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 0);
        check_eq("tp_lb", load_data, 32'hFFFF_FF80);
        run_op(8'h08, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 0);
        check_eq("tp_lbu", load_data, 32'h0000_0080);
        run_op(8'h10, 32'h0000_1002, 32'h0, 32'h80FF_FFFF, 0, 0);
        check_eq("tp_lhu", load_data, 32'h0000_80FF);
        run_op(8'h02, 32'h0000_1000, 32'h0, 32'h1234_9ABC, 1, 0);
        run_op(8'h01, 32'h0000_1001, 32'h0, 32'h0000_7F00, 0, 0);
        run_op(8'h20, 32'h0000_2002, 32'h1234_56AB, 32'h0, 0, 0);
        run_op(8'h40, 32'h0000_2002, 32'h1234_56AB, 32'h0, 0, 0);
        run_op(8'h80, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 2, 0);
        // withheld READY: timeout with an extra issue attempt while busy
        run_op(8'h04, 32'h0000_4000, 32'h0, 32'h1111_2222, 5, 1);
        // READY in the expiry cycle completes normally
        run_op(8'h08, 32'h0000_4001, 32'h0, 32'h0000_F500, TMO - 1, 0);
        // multi-hot priority
        run_op(8'h24, 32'h0000_5003, 32'h0000_00AA, 32'h5555_6666, 0, 0);
        run_op(8'h03, 32'h0000_5002, 32'h0, 32'h8001_0002, 0, 0);
        // misaligned accesses
        run_op(8'h04, 32'h0000_1001, 32'h0, 32'h1122_3344, 0, 0);
        run_op(8'h40, 32'h0000_6003, 32'hBEEF_1357, 32'h0, 0, 0);
        run_op(8'h02, 32'h0000_6003, 32'h0, 32'hC000_0001, 0, 0);

        // ISSUE_VALID without any op is ignored
        issue_valid = 1'b1; inst = 8'h00; addr = 32'h0000_7000;
        step();
        issue_valid = 1'b0;
        check_eq("noop_ready", issue_ready, 1'b1);
        check_eq("noop_req", d_mem_valid, 1'b0);
        step();
        check_eq("noop_done", done, 1'b0);

        // reset while a request is outstanding
        issue_valid = 1'b1; inst = 8'h04; addr = 32'h0000_8000;
        step();
        issue_valid = 1'b0; inst = 8'h00;
        check_eq("rreq_valid", d_mem_valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rreq_valid_drop", d_mem_valid, 1'b0);
        check_eq("rreq_ready", issue_ready, 1'b1);
        check_eq("rreq_done", done, 1'b0);
        last_load = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rreq_no_done", done, 1'b0);
        end
        check_eq("rreq_load_data", load_data, 32'h0);
        run_op(8'h10, 32'h0000_9000, 32'h0, 32'hFFFF_8001, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peak_lsu.md
Name: peak_lsu

Overview:
Load/store unit directly downstream of the execute-stage ALU. It takes the effective address computed by the ALU (RSLT) and the RS2 store operand for one decoded load/store instruction. It runs a single data-memory transaction over a valid/ready bus and returns sign/zero-extended load data, or a store-complete pulse, to writeback. The unit handles one access at a time and stalls issue while busy.

Parameters:
TIMEOUT_CYCLES, 0, bus wait limit in cycles; 0 = no timeout; otherwise abort with BUS_ERR after this many cycles of D_MEM_VALID without D_MEM_READY.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous active-high reset
ISSUE_VALID  input  1  instruction offered this cycle
ISSUE_READY  output  1  unit idle, accepts issue
INST_LB, INST_LH, INST_LW, INST_LBU, INST_LHU, INST_SB, INST_SH, INST_SW  input  1 each  one-hot decoded op
ADDR  input  32  effective address (ALU RSLT)
WDATA_IN  input  32  store operand (RS2)
D_MEM_VALID  output  1  bus request
D_MEM_READY  input  1  bus accept/complete
D_MEM_ADDR  output  32  word-aligned address {ADDR[31:2],2'b00}
D_MEM_WSTRB  output  4  byte enables; 4'b0000 = read
D_MEM_WDATA  output  32  lane-replicated store data
D_MEM_RDATA  input  32  read data, valid with D_MEM_READY
DONE  output  1  one-cycle completion pulse
LOAD_VALID  output  1  with DONE: result is load data
LOAD_DATA  output  32  extended load result
BUS_ERR  output  1  with DONE: timeout abort
MISALIGN  output  1  with DONE: misaligned trap (only with the optional feature)

Behaviour:
- Reset values: all outputs 0 except ISSUE_READY=1; state IDLE; timeout counter 0.
- States: IDLE, REQ, RESP.
- IDLE: ISSUE_READY=1. Accept on ISSUE_VALID & (any INST_* high). Capture op, ADDR, WDATA_IN. Next state is REQ. ISSUE_VALID with no INST_* high is ignored, and the unit stays in IDLE. Multi-hot INST_* is illegal; priority is LW>LH>LHU>LB>LBU>SW>SH>SB.
- REQ: D_MEM_VALID=1; ADDR, WSTRB and WDATA are held stable until D_MEM_READY. On D_MEM_READY, register D_MEM_RDATA, drop D_MEM_VALID and go to RESP. Earliest D_MEM_VALID is the cycle after issue.
- RESP: DONE=1 for exactly one cycle. LOAD_VALID=1 for loads. Next state is IDLE; ISSUE_READY returns in the following cycle. There is no back-to-back acceptance in RESP.
- Minimum latency, issue edge to DONE: 2 cycles after the issue cycle, with zero-wait READY.
- Store strobes:
  - SB: 4'b0001<<ADDR[1:0], WDATA={4{rs2[7:0]}}.
  - SH: 4'b0011<<{ADDR[1],1'b0}, WDATA={2{rs2[15:0]}}.
  - SW: 4'b1111, WDATA=rs2.
  - Loads drive WSTRB=0 and WDATA=0.
- Load extraction:
  - Byte lane = ADDR[1:0]; half lane = ADDR[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - LOAD_DATA is held until the next DONE.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments each REQ cycle without READY.
  - On reaching TIMEOUT_CYCLES, drop D_MEM_VALID and go to RESP with BUS_ERR=1, LOAD_VALID=0, LOAD_DATA unchanged.
  - READY arriving in the same cycle as expiry wins: normal completion.
- RST in any state: return to IDLE next edge, D_MEM_VALID=0, no DONE. The aborted op is lost.
- Without the optional feature, misaligned addresses are not checked. The access uses the aligned word and the lane bits above, so an LH at offset 3 reads lanes 3..2 per ADDR[1]=1 (bit 0 ignored).

Optional Feature:
Macro PEAK_LSU_MISALIGN_TRAP_EN.
- Defined: at acceptance, an LH/LHU/SH with ADDR[0]=1, or an LW/SW with ADDR[1:0]!=0, skips REQ. The unit goes IDLE->RESP with DONE=1, MISALIGN=1, LOAD_VALID=0 and issues no bus request.
- Undefined: the MISALIGN port is tied 0 and accesses proceed as described in Behaviour.

Test Plan:
- LW ADDR=0x1000, RDATA=0x8765_4321, READY immediate -> D_MEM_ADDR=0x1000, WSTRB=0, DONE 2 cycles after issue, LOAD_DATA=0x8765_4321.
- LB ADDR=0x1003, RDATA=0x80FF_FFFF -> LOAD_DATA=0xFFFF_FF80; same with LBU -> 0x0000_0080; LHU ADDR=0x1002 -> 0x0000_80FF.
- SB ADDR=0x2002 RS2=0x1234_56AB -> WSTRB=4'b0100, WDATA=0xABAB_ABAB; SH ADDR=0x2002 -> WSTRB=4'b1100, WDATA=0x56AB_56AB; DONE=1, LOAD_VALID=0.
- READY withheld 5 cycles -> D_MEM_VALID, ADDR and WSTRB stable throughout, ISSUE_READY=0, second ISSUE_VALID ignored; TIMEOUT_CYCLES=3 -> BUS_ERR with DONE after the 3rd wait cycle.
- RST asserted during REQ -> D_MEM_VALID=0 and ISSUE_READY=1 next cycle, no DONE pulse.
- Macro defined: LW ADDR=0x1001 -> no D_MEM_VALID, DONE+MISALIGN one cycle after issue; macro undefined -> normal access to 0x1000.
